// File: rtl/lib_arbiter_pkg.sv
// Shared arbiter/event-stream constants, packet field offsets and the decoded event record.
package lib_arbiter_pkg;

  localparam int SIZE    = 32;
  localparam int ROW_ADD = 3;
  localparam int COL_ADD = 3;
  localparam int COLS1   = 8;
  localparam int WIDTH   = SIZE + ROW_ADD + COL_ADD + 1;
  localparam int EPOCH_W = 16;
  localparam int CNT_W   = 32;

  // Packet layout, LSB first: polarity, column, row, timestamp.
  localparam int POL_BIT = 0;
  localparam int COL_LSB = 1;
  localparam int ROW_LSB = COL_LSB + COL_ADD;
  localparam int TS_LSB  = WIDTH - SIZE;

  typedef struct packed {
    logic [ROW_ADD-1:0]      row;
    logic [COL_ADD-1:0]      col;
    logic                    pol;
    logic [EPOCH_W+SIZE-1:0] ts_ext;
  } dec_evt_t;

  localparam int DEC_EVT_W = $bits(dec_evt_t);

endpackage

// File: rtl/lib_event_fifo.sv
// Two-entry first-word-fall-through FIFO with registered full/empty flags.
module lib_event_fifo #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] din_i,
  output logic [W-1:0] dout_o,
  output logic         full_o,
  output logic         empty_o
);

  logic [W-1:0] mem0, mem1;
  logic [1:0]   count, count_nxt;
  logic         do_push, do_pop;

  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign dout_o  = mem0;

  always_comb begin
    count_nxt = count + {1'b0, do_push} - {1'b0, do_pop};
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      // NOTE: the storage is reset too so the data outputs read 0 after reset; at two entries that is cheap.
      mem0    <= '0;
      mem1    <= '0;
      count   <= 2'd0;
      full_o  <= 1'b0;
      empty_o <= 1'b1;
    end else begin
      count   <= count_nxt;
      full_o  <= (count_nxt == 2'd2);
      empty_o <= (count_nxt == 2'd0);
      case ({do_push, do_pop})
        2'b10: begin
          if (count == 2'd0) mem0 <= din_i;
          else               mem1 <= din_i;
        end
        2'b01:   mem0 <= mem1;
        // Push with pop is only possible with one entry held (push needs !full).
        2'b11:   mem0 <= din_i;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/event_packet_decoder.sv
// Unpacks arbiter event packets, extends timestamps with an epoch, drops out-of-order packets.
// Optional per-polarity counters: define EBC_DEC_POL_STATS_EN.
module event_packet_decoder
  import lib_arbiter_pkg::*;
(
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic                      pkt_valid_i,
  input  logic [WIDTH-1:0]          pkt_data_i,
  output logic                      pkt_ready_o,
  output logic                      evt_valid_o,
  input  logic                      evt_ready_i,
  output logic [ROW_ADD-1:0]        evt_row_o,
  output logic [COL_ADD-1:0]        evt_col_o,
  output logic [ROW_ADD+COL_ADD-1:0] evt_pixel_o,
  output logic                      evt_pol_o,
  output logic [EPOCH_W+SIZE-1:0]   evt_ts_o,
  output logic                      wrap_o,
  output logic                      ooo_err_o,
  output logic [CNT_W-1:0]          evt_cnt_o,
  output logic [CNT_W-1:0]          drop_cnt_o,
  output logic [CNT_W-1:0]          on_cnt_o,
  output logic [CNT_W-1:0]          off_cnt_o
);

  localparam logic [SIZE-1:0] HALF_RANGE = {1'b1, {(SIZE-1){1'b0}}};

  logic [SIZE-1:0]    last_ts, ts;
  logic [EPOCH_W-1:0] epoch, epoch_nxt;
  logic               first_seen;
  logic               hs, is_wrap, is_drop, push;
  logic               fifo_full, fifo_empty;
  dec_evt_t           din, head;

  assign ts          = pkt_data_i[TS_LSB +: SIZE];
  assign hs          = pkt_valid_i & pkt_ready_o;
  assign pkt_ready_o = ~fifo_full;
  assign push        = hs & ~is_drop;

  // A backwards step of at least half the timestamp range is a wrap, anything smaller is reordering.
  always_comb begin
    is_wrap   = 1'b0;
    is_drop   = 1'b0;
    epoch_nxt = epoch;
    if (first_seen && (ts < last_ts)) begin
      if ((last_ts - ts) >= HALF_RANGE) begin
        is_wrap   = 1'b1;
        epoch_nxt = epoch + EPOCH_W'(1);
      end else begin
        is_drop = 1'b1;
      end
    end
  end

  always_comb begin
    din.row    = pkt_data_i[ROW_LSB +: ROW_ADD];
    din.col    = pkt_data_i[COL_LSB +: COL_ADD];
    din.pol    = pkt_data_i[POL_BIT];
    din.ts_ext = {epoch_nxt, ts};
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      last_ts    <= '0;
      epoch      <= '0;
      first_seen <= 1'b0;
      evt_cnt_o  <= '0;
      drop_cnt_o <= '0;
      wrap_o     <= 1'b0;
      ooo_err_o  <= 1'b0;
    end else begin
      wrap_o    <= hs & is_wrap;
      ooo_err_o <= hs & is_drop;
      if (hs) begin
        if (is_drop) begin
          if (drop_cnt_o != '1) drop_cnt_o <= drop_cnt_o + CNT_W'(1);
        end else begin
          last_ts    <= ts;
          epoch      <= epoch_nxt;
          first_seen <= 1'b1;
          evt_cnt_o  <= evt_cnt_o + CNT_W'(1);
        end
      end
    end
  end

  lib_event_fifo #(.W(DEC_EVT_W)) u_fifo (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .push_i  (push),
    .pop_i   (evt_ready_i),
    .din_i   (din),
    .dout_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // COLS1 is a power of two, so row*COLS1+col is plain concatenation.
  assign evt_valid_o = ~fifo_empty;
  assign evt_row_o   = head.row;
  assign evt_col_o   = head.col;
  assign evt_pixel_o = {head.row, head.col};
  assign evt_pol_o   = head.pol;
  assign evt_ts_o    = head.ts_ext;

`ifdef EBC_DEC_POL_STATS_EN
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      on_cnt_o  <= '0;
      off_cnt_o <= '0;
    end else if (push) begin
      if (din.pol) on_cnt_o  <= on_cnt_o + CNT_W'(1);
      else         off_cnt_o <= off_cnt_o + CNT_W'(1);
    end
  end
`else
  assign on_cnt_o  = '0;
  assign off_cnt_o = '0;
`endif

endmodule

// File: tb/tb_event_packet_decoder.sv
// Scoreboard bench for event_packet_decoder: directed packets, expected events queued, monitor compares.
module tb_event_packet_decoder;
  import lib_arbiter_pkg::*;

  logic                       clk_i = 1'b0;
  logic                       reset_i = 1'b1;
  logic                       pkt_valid_i = 1'b0;
  logic [WIDTH-1:0]           pkt_data_i = '0;
  logic                       pkt_ready_o;
  logic                       evt_valid_o;
  logic                       evt_ready_i = 1'b1;
  logic [ROW_ADD-1:0]         evt_row_o;
  logic [COL_ADD-1:0]         evt_col_o;
  logic [ROW_ADD+COL_ADD-1:0] evt_pixel_o;
  logic                       evt_pol_o;
  logic [EPOCH_W+SIZE-1:0]    evt_ts_o;
  logic                       wrap_o, ooo_err_o;
  logic [CNT_W-1:0]           evt_cnt_o, drop_cnt_o, on_cnt_o, off_cnt_o;

  typedef struct {
    logic [2:0]  row;
    logic [2:0]  col;
    logic [5:0]  pix;
    logic        pol;
    logic [47:0] ts;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk_i = ~clk_i;

  event_packet_decoder dut (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .pkt_valid_i (pkt_valid_i),
    .pkt_data_i  (pkt_data_i),
    .pkt_ready_o (pkt_ready_o),
    .evt_valid_o (evt_valid_o),
    .evt_ready_i (evt_ready_i),
    .evt_row_o   (evt_row_o),
    .evt_col_o   (evt_col_o),
    .evt_pixel_o (evt_pixel_o),
    .evt_pol_o   (evt_pol_o),
    .evt_ts_o    (evt_ts_o),
    .wrap_o      (wrap_o),
    .ooo_err_o   (ooo_err_o),
    .evt_cnt_o   (evt_cnt_o),
    .drop_cnt_o  (drop_cnt_o),
    .on_cnt_o    (on_cnt_o),
    .off_cnt_o   (off_cnt_o)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [WIDTH-1:0] mk(input logic [31:0] ts, input logic [2:0] r,
                                          input logic [2:0] c, input logic p);
    return {ts, r, c, p};
  endfunction

  // Issues one packet; returns just after the edge that accepted it.
  task automatic send(input logic [WIDTH-1:0] d, input logic exp_push,
                      input logic [2:0] er, input logic [2:0] ec, input logic [5:0] epix,
                      input logic ep, input logic [47:0] ets, input logic ewrap, input logic eooo);
    logic rdy;
    bit   done = 0;
    if (exp_push) sb_q.push_back('{er, ec, epix, ep, ets});
    pkt_valid_i = 1'b1;
    pkt_data_i  = d;
    for (int i = 0; i < 20 && !done; i++) begin
      rdy = pkt_ready_o;
      @(posedge clk_i);
      #1;
      if (rdy) done = 1;
    end
    pkt_valid_i = 1'b0;
    if (!done) check("send_timeout", {63'd0, pkt_ready_o}, 64'd1);
    else begin
      check("wrap_o", {63'd0, wrap_o}, {63'd0, ewrap});
      check("ooo_err_o", {63'd0, ooo_err_o}, {63'd0, eooo});
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 50 && sb_q.size() != 0; i++) @(posedge clk_i);
    #1;
    check("drain_left", 64'(sb_q.size()), 64'd0);
    check("drain_valid", {63'd0, evt_valid_o}, 64'd0);
  endtask

  // Monitor: a transfer happens at the next posedge whenever valid & ready hold at the negedge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_i);
      if (evt_valid_o && evt_ready_i && !reset_i) begin
        if (sb_q.size() == 0) check("unexpected_evt", {63'd0, evt_valid_o}, 64'd0);
        else begin
          e = sb_q.pop_front();
          check("evt_row", 64'(evt_row_o), 64'(e.row));
          check("evt_col", 64'(evt_col_o), 64'(e.col));
          check("evt_pixel", 64'(evt_pixel_o), 64'(e.pix));
          check("evt_pol", {63'd0, evt_pol_o}, {63'd0, e.pol});
          check("evt_ts", 64'(evt_ts_o), 64'(e.ts));
        end
      end
    end
  end

  initial begin
    repeat (2) @(posedge clk_i);
    #1;
    reset_i = 1'b0;
    check("rst_evt_valid", {63'd0, evt_valid_o}, 64'd0);
    check("rst_pkt_ready", {63'd0, pkt_ready_o}, 64'd1);
    check("rst_evt_cnt", 64'(evt_cnt_o), 64'd0);
    check("rst_drop_cnt", 64'(drop_cnt_o), 64'd0);
    check("rst_ts", 64'(evt_ts_o), 64'd0);
    check("rst_row", 64'(evt_row_o), 64'd0);

    // Basic decode, literal packet to pin down the bit layout.
    send(39'h3257, 1, 3'd5, 3'd3, 6'd43, 1, 48'd100, 0, 0);
    check("lat_evt_valid", {63'd0, evt_valid_o}, 64'd1);
    check("evt_cnt_1", 64'(evt_cnt_o), 64'd1);

    // Out-of-order packet is dropped.
    send(mk(32'd90, 3'd1, 3'd1, 0), 0, 0, 0, 0, 0, 0, 0, 1);
    check("drop_no_evt", {63'd0, evt_valid_o}, 64'd0);
    check("drop_cnt_1", 64'(drop_cnt_o), 64'd1);
    @(posedge clk_i); #1;
    check("ooo_pulse_end", {63'd0, ooo_err_o}, 64'd0);

    // Timestamp wrap moves to epoch 1.
    send(mk(32'hFFFF_FFF0, 3'd2, 3'd7, 0), 1, 3'd2, 3'd7, 6'd23, 0, 48'h0_FFFF_FFF0, 0, 0);
    send(mk(32'h10, 3'd7, 3'd0, 1), 1, 3'd7, 3'd0, 6'd56, 1, 48'h1_0000_0010, 1, 0);
    @(posedge clk_i); #1;
    check("wrap_pulse_end", {63'd0, wrap_o}, 64'd0);

    // Equal timestamps both pass.
    send(mk(32'd200, 3'd3, 3'd4, 1), 1, 3'd3, 3'd4, 6'd28, 1, 48'h1_0000_00C8, 0, 0);
    send(mk(32'd200, 3'd4, 3'd4, 0), 1, 3'd4, 3'd4, 6'd36, 0, 48'h1_0000_00C8, 0, 0);
    drain();
    check("evt_cnt_5", 64'(evt_cnt_o), 64'd5);

    // Backpressure: two stored, third held until the consumer releases.
    evt_ready_i = 1'b0;
    send(mk(32'd300, 3'd0, 3'd1, 1), 1, 3'd0, 3'd1, 6'd1, 1, 48'h1_0000_012C, 0, 0);
    send(mk(32'd400, 3'd6, 3'd6, 0), 1, 3'd6, 3'd6, 6'd54, 0, 48'h1_0000_0190, 0, 0);
    check("full_ready_low", {63'd0, pkt_ready_o}, 64'd0);
    fork
      send(mk(32'd500, 3'd7, 3'd7, 1), 1, 3'd7, 3'd7, 6'd63, 1, 48'h1_0000_01F4, 0, 0);
      begin
        repeat (3) begin
          @(posedge clk_i); #1;
          check("stall_ready", {63'd0, pkt_ready_o}, 64'd0);
          check("stall_ts", 64'(evt_ts_o), 64'h1_0000_012C);
        end
        evt_ready_i = 1'b1;
      end
    join
    drain();
    check("evt_cnt_8", 64'(evt_cnt_o), 64'd8);
    check("drop_cnt_still_1", 64'(drop_cnt_o), 64'd1);

    // Reset with two entries queued discards them and clears the epoch.
    evt_ready_i = 1'b0;
    send(mk(32'd600, 3'd1, 3'd2, 1), 0, 0, 0, 0, 0, 0, 0, 0);
    send(mk(32'd700, 3'd2, 3'd2, 0), 0, 0, 0, 0, 0, 0, 0, 0);
    reset_i = 1'b1;
    @(posedge clk_i); #1;
    reset_i = 1'b0;
    check("mid_rst_valid", {63'd0, evt_valid_o}, 64'd0);
    check("mid_rst_ready", {63'd0, pkt_ready_o}, 64'd1);
    check("mid_rst_evt_cnt", 64'(evt_cnt_o), 64'd0);
    check("mid_rst_drop_cnt", 64'(drop_cnt_o), 64'd0);
    evt_ready_i = 1'b1;

    // First packet after reset is unchecked and carries epoch 0.
    send(mk(32'd5, 3'd1, 3'd0, 1), 1, 3'd1, 3'd0, 6'd8, 1, 48'd5, 0, 0);
    send(mk(32'd6, 3'd0, 3'd0, 1), 1, 3'd0, 3'd0, 6'd0, 1, 48'd6, 0, 0);
    send(mk(32'd7, 3'd0, 3'd2, 0), 1, 3'd0, 3'd2, 6'd2, 0, 48'd7, 0, 0);
    send(mk(32'd8, 3'd3, 3'd3, 1), 1, 3'd3, 3'd3, 6'd27, 1, 48'd8, 0, 0);
    send(mk(32'd9, 3'd1, 3'd1, 0), 1, 3'd1, 3'd1, 6'd9, 0, 48'd9, 0, 0);
    drain();
    check("evt_cnt_post_rst", 64'(evt_cnt_o), 64'd5);
`ifdef EBC_DEC_POL_STATS_EN
    check("on_cnt", 64'(on_cnt_o), 64'd3);
    check("off_cnt", 64'(off_cnt_o), 64'd2);
`else
    check("on_cnt_tied", 64'(on_cnt_o), 64'd0);
    check("off_cnt_tied", 64'(off_cnt_o), 64'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
